spread_signal_gen: RTL and testbench
====================================

Name: spread_signal_gen

Overview:
Downstream consumer of the order book's best_bid/best_ask. On each book update it validates the top of book, computes spread and mid, and emits a single-unit momentum order when the spread is tight and the mid has moved. Orders leave over a valid/ready handshake toward the order-entry stage. The block tracks net position with a hard limit and enforces a post-trade cooldown.

Parameters:
PRICE_W, 32, price width; must match the book price width.
COOLDOWN_CYCLES, 16, idle cycles enforced after each accepted order; 0 means no cooldown.
MAX_POSITION, 8, absolute net-position limit in units; 1..127.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
best_bid  in  PRICE_W  top bid from order book
best_ask  in  PRICE_W  top ask from order book
book_valid  in  1  one-cycle pulse: best_bid/best_ask freshly updated
spread_thresh  in  PRICE_W  maximum tradable spread, static during operation
enable  in  1  permits new evaluations
order_valid  out  1  order available
order_ready  in  1  downstream accepts order
order_side  out  1  0 = buy, 1 = sell
order_price  out  PRICE_W  limit price
position  out  8  signed net position, two's complement
signal_count  out  16  accepted orders, saturates at 16'hFFFF
busy  out  1  high whenever state != IDLE

Behaviour:
- Clocking and reset: single clock domain on clk; reset_n is asynchronous and active-low. All state and outputs reset to 0: state = IDLE, prev_mid_valid = 0, prev_mid = 0, captured bid/ask = 0.
- All outputs are registered.
- FSM states: IDLE, EVAL, ISSUE, COOLDOWN.
- IDLE: if book_valid && enable, capture best_bid/best_ask and go to EVAL. Otherwise stay.
- EVAL (exactly 1 cycle):
  - The book is invalid if bid == 0, or ask == all-ones, or bid >= ask. An invalid book returns to IDLE with no update to prev_mid.
  - For a valid book: spread = ask - bid (PRICE_W, unsigned, no underflow); mid = ({1'b0,bid} + {1'b0,ask}) >> 1, truncated to PRICE_W.
  - prev_mid <= mid and prev_mid_valid <= 1 for every valid book, whether or not an order is issued.
  - An order is generated only if prev_mid_valid was already 1 and spread <= spread_thresh.
  - mid > prev_mid: buy at ask, blocked if position == +MAX_POSITION.
  - mid < prev_mid: sell at bid, blocked if position == -MAX_POSITION.
  - mid == prev_mid: no order.
  - If an order is generated: load order_side/order_price and go to ISSUE. Otherwise go to IDLE.
- ISSUE:
  - order_valid = 1; side and price are held stable until order_valid && order_ready.
  - There is no retraction: deasserting enable does not cancel a pending order.
  - On handshake: order_valid drops the next cycle; position moves ±1; signal_count increments with saturation.
  - After handshake: if COOLDOWN_CYCLES == 0, go to IDLE. Otherwise load cnt = COOLDOWN_CYCLES-1 and go to COOLDOWN.
- COOLDOWN: if cnt == 0 go to IDLE, else decrement. With handshake in cycle H, the block is in COOLDOWN for cycles H+1..H+COOLDOWN_CYCLES.
- book_valid in any state other than IDLE is dropped; no queuing.
- Latency: book_valid sampled in IDLE at cycle N gives order_valid high in cycle N+2.
- Reset asserted mid-ISSUE: the order is abandoned, order_valid is 0 immediately (asynchronous), and position is cleared.

Optional Feature:
SIG_DROP_CNT_EN
- Defined: adds output drop_count (16 bits, reset 0, saturating). It increments once per book_valid pulse seen while busy == 1 or while enable == 0.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
1. Reset: hold reset_n low mid-operation -> every output reads 0 and busy = 0; after release, the first valid book only seeds prev_mid (no order).
2. Seed then buy: thresh = 4; book 100/102, then 101/103 pulsed at cycle N -> order_valid in N+2, side = 0, price = 103; with ready = 1: position = 1, signal_count = 1.
3. Backpressure: ready low for 5 cycles -> order_valid/side/price stable; book_valid pulses during this are dropped (drop_count += each with macro); position changes only on the handshake cycle.
4. Filtering:
   - book 100/110, thresh = 4 -> no order, but prev_mid = 105.
   - book 105/105 -> ignored, prev_mid unchanged.
   - ask = 32'hFFFFFFFF -> ignored.
5. Position limit: MAX_POSITION = 2, COOLDOWN_CYCLES = 0, rising mids 101, 102, 103, 104 -> buys at mids 102 and 103, 104 suppressed, position = 2; then mid 103 -> sell at bid, position = 1.
6. Cooldown: COOLDOWN_CYCLES = 16, handshake at cycle H:
   - book_valid at H+10 -> no order (drop_count = 1 with macro).
   - book_valid at H+17 -> accepted and evaluated.
   - busy = 1 for H+1..H+16.

Source files
------------

// File: rtl/spread_signal_gen_if.sv
// Order-entry handshake carried by spread_signal_gen.
// valid/ready: the master raises order_valid together with order_side and
// order_price and holds all three stable until a rising clock edge at which
// order_valid && order_ready; that edge is the single transfer of the order.
interface spread_signal_gen_if #(
  parameter int PRICE_W = 32
) ();
  logic               order_valid;
  logic               order_ready;
  logic               order_side;
  logic [PRICE_W-1:0] order_price;

  modport master (
    output order_valid,
    output order_side,
    output order_price,
    input  order_ready
  );

  modport slave (
    input  order_valid,
    input  order_side,
    input  order_price,
    output order_ready
  );
endinterface

// File: rtl/spread_signal_gen.sv
// spread_signal_gen: validates top of book, computes spread/mid and emits
// single-unit momentum orders with a net-position limit and post-trade
// cooldown. Optional macro SIG_DROP_CNT_EN adds drop_count, counting
// book_valid pulses that arrive while busy or while enable is low.
module spread_signal_gen #(
  parameter int PRICE_W         = 32,
  parameter int COOLDOWN_CYCLES = 16,
  parameter int MAX_POSITION    = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PRICE_W-1:0]  best_bid,
  input  logic [PRICE_W-1:0]  best_ask,
  input  logic                book_valid,
  input  logic [PRICE_W-1:0]  spread_thresh,
  input  logic                enable,
  spread_signal_gen_if.master ord,
  output logic [7:0]          position,
  output logic [15:0]         signal_count,
  output logic                busy,
  output logic [1:0]          dbg_state
`ifdef SIG_DROP_CNT_EN
  ,
  output logic [15:0]         drop_count
`endif
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] EVAL     = 2'd1;
  localparam logic [1:0] ISSUE    = 2'd2;
  localparam logic [1:0] COOLDOWN = 2'd3;

  localparam logic signed [7:0] POS_MAX  = 8'(MAX_POSITION);
  localparam logic signed [7:0] POS_MIN  = -POS_MAX;
  localparam logic [15:0]       CNT_LOAD = 16'(COOLDOWN_CYCLES - 1);

  logic [1:0]         state_q, state_d;
  logic [PRICE_W-1:0] bid_q, bid_d;
  logic [PRICE_W-1:0] ask_q, ask_d;
  logic [PRICE_W-1:0] prev_mid_q, prev_mid_d;
  logic               prev_mid_valid_q, prev_mid_valid_d;
  logic               side_q, side_d;
  logic [PRICE_W-1:0] price_q, price_d;
  logic               valid_q, valid_d;
  logic signed [7:0]  pos_q, pos_d;
  logic [15:0]        sig_cnt_q, sig_cnt_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               busy_q, busy_d;
`ifdef SIG_DROP_CNT_EN
  logic [15:0]        drop_q, drop_d;
`endif

  logic [PRICE_W:0]   mid_sum;
  logic [PRICE_W-1:0] mid;
  logic [PRICE_W-1:0] spread;
  logic               book_ok;

  // Next-state logic: FSM, evaluation datapath, position and counters.
  always_comb begin
    state_d          = state_q;
    bid_d            = bid_q;
    ask_d            = ask_q;
    prev_mid_d       = prev_mid_q;
    prev_mid_valid_d = prev_mid_valid_q;
    side_d           = side_q;
    price_d          = price_q;
    pos_d            = pos_q;
    sig_cnt_d        = sig_cnt_q;
    cnt_d            = cnt_q;

    // Widened sum keeps the carry so the mid never wraps.
    mid_sum = {1'b0, bid_q} + {1'b0, ask_q};
    mid     = PRICE_W'(mid_sum >> 1);
    spread  = ask_q - bid_q;
    book_ok = (bid_q != '0) && (ask_q != '1) && (bid_q < ask_q);

    case (state_q)
      IDLE: begin
        if (book_valid && enable) begin
          bid_d   = best_bid;
          ask_d   = best_ask;
          state_d = EVAL;
        end
      end
      EVAL: begin
        state_d = IDLE;
        if (book_ok) begin
          prev_mid_d       = mid;
          prev_mid_valid_d = 1'b1;
          if (prev_mid_valid_q && (spread <= spread_thresh)) begin
            if ((mid > prev_mid_q) && (pos_q != POS_MAX)) begin
              side_d  = 1'b0;
              price_d = ask_q;
              state_d = ISSUE;
            end else if ((mid < prev_mid_q) && (pos_q != POS_MIN)) begin
              side_d  = 1'b1;
              price_d = bid_q;
              state_d = ISSUE;
            end
          end
        end
      end
      ISSUE: begin
        // Order is never retracted; only the handshake leaves ISSUE.
        if (valid_q && ord.order_ready) begin
          pos_d = side_q ? (pos_q - 8'sd1) : (pos_q + 8'sd1);
          if (sig_cnt_q != 16'hFFFF) sig_cnt_d = sig_cnt_q + 16'd1;
          if (COOLDOWN_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = COOLDOWN;
          end
        end
      end
      default: begin
        if (cnt_q == 16'd0) state_d = IDLE;
        else                cnt_d   = cnt_q - 16'd1;
      end
    endcase

    // Outputs are registered from the next state so they align with it.
    valid_d = (state_d == ISSUE);
    busy_d  = (state_d != IDLE);

`ifdef SIG_DROP_CNT_EN
    drop_d = drop_q;
    if (book_valid && (busy_q || !enable) && (drop_q != 16'hFFFF))
      drop_d = drop_q + 16'd1;
`endif
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      bid_q            <= '0;
      ask_q            <= '0;
      prev_mid_q       <= '0;
      prev_mid_valid_q <= 1'b0;
      side_q           <= 1'b0;
      price_q          <= '0;
      valid_q          <= 1'b0;
      pos_q            <= '0;
      sig_cnt_q        <= '0;
      cnt_q            <= '0;
      busy_q           <= 1'b0;
`ifdef SIG_DROP_CNT_EN
      drop_q           <= '0;
`endif
    end else begin
      state_q          <= state_d;
      bid_q            <= bid_d;
      ask_q            <= ask_d;
      prev_mid_q       <= prev_mid_d;
      prev_mid_valid_q <= prev_mid_valid_d;
      side_q           <= side_d;
      price_q          <= price_d;
      valid_q          <= valid_d;
      pos_q            <= pos_d;
      sig_cnt_q        <= sig_cnt_d;
      cnt_q            <= cnt_d;
      busy_q           <= busy_d;
`ifdef SIG_DROP_CNT_EN
      drop_q           <= drop_d;
`endif
    end
  end

  assign ord.order_valid = valid_q;
  assign ord.order_side  = side_q;
  assign ord.order_price = price_q;
  assign position        = pos_q;
  assign signal_count    = sig_cnt_q;
  assign busy            = busy_q;
  assign dbg_state       = state_q;
`ifdef SIG_DROP_CNT_EN
  assign drop_count      = drop_q;
`endif

endmodule

// File: tb/tb_spread_signal_gen.sv
// Directed bench for spread_signal_gen: instance A uses default parameters
// (cooldown 16, limit 8), instance B uses limit 2 with no cooldown.
module tb_spread_signal_gen;
  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] bid, ask, thresh;
  logic         bv, a_en, b_en;

  logic [7:0]  a_pos, b_pos;
  logic [15:0] a_cnt, b_cnt;
  logic        a_busy, b_busy;
  logic [1:0]  a_dbg, b_dbg;
`ifdef SIG_DROP_CNT_EN
  logic [15:0] a_drop, b_drop;
`endif

  spread_signal_gen_if #(.PRICE_W(W)) a_if ();
  spread_signal_gen_if #(.PRICE_W(W)) b_if ();

  spread_signal_gen #(.PRICE_W(W), .COOLDOWN_CYCLES(16), .MAX_POSITION(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .best_bid(bid), .best_ask(ask),
    .book_valid(bv), .spread_thresh(thresh), .enable(a_en), .ord(a_if.master),
    .position(a_pos), .signal_count(a_cnt), .busy(a_busy), .dbg_state(a_dbg)
`ifdef SIG_DROP_CNT_EN
    , .drop_count(a_drop)
`endif
  );

  spread_signal_gen #(.PRICE_W(W), .COOLDOWN_CYCLES(0), .MAX_POSITION(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .best_bid(bid), .best_ask(ask),
    .book_valid(bv), .spread_thresh(thresh), .enable(b_en), .ord(b_if.master),
    .position(b_pos), .signal_count(b_cnt), .busy(b_busy), .dbg_state(b_dbg)
`ifdef SIG_DROP_CNT_EN
    , .drop_count(b_drop)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [W:0] exp_q[$];
  int exp_pos[2];
  int exp_cnt[2];
  int checks   = 0;
  int failures = 0;
  logic [W:0] e;
  int k;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic ov(input int u);
    return (u == 1) ? b_if.order_valid : a_if.order_valid;
  endfunction
  function automatic logic os(input int u);
    return (u == 1) ? b_if.order_side : a_if.order_side;
  endfunction
  function automatic logic [W-1:0] op(input int u);
    return (u == 1) ? b_if.order_price : a_if.order_price;
  endfunction
  function automatic logic bz(input int u);
    return (u == 1) ? b_busy : a_busy;
  endfunction
  function automatic logic [7:0] ps(input int u);
    return (u == 1) ? b_pos : a_pos;
  endfunction
  function automatic logic [15:0] sc(input int u);
    return (u == 1) ? b_cnt : a_cnt;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic pulse(input logic [W-1:0] b, input logic [W-1:0] a);
    @(posedge clk); #1;
    bid = b;
    ask = a;
    bv  = 1'b1;
    @(posedge clk); #1;
    bv  = 1'b0;
  endtask

  // Drive one book and check the order (or its absence) at N+2, then let
  // the instance return to idle and check position/count.
  task automatic run_book(input int u, input logic [W-1:0] b, input logic [W-1:0] a,
                          input bit exp_ord, input logic s, input logic [W-1:0] p);
    logic [W:0]  ee;
    int          kk;
    logic [7:0]  pe;
    logic [15:0] ce;
    if (exp_ord) exp_q.push_back({s, p});
    pulse(b, a);
    @(posedge clk);
    @(negedge clk);
    check("order_valid", 32'(ov(u)), 32'(exp_ord));
    if (exp_ord) begin
      ee = exp_q.pop_front();
      check("order_side", 32'(os(u)), 32'(ee[W]));
      check("order_price", op(u), ee[W-1:0]);
      exp_pos[u] += s ? -1 : 1;
      exp_cnt[u]++;
    end
    kk = 0;
    while (bz(u) && kk < 40) begin
      @(negedge clk);
      kk++;
    end
    check("return_idle", 32'(bz(u)), 32'd0);
    pe = 8'(exp_pos[u]);
    ce = 16'(exp_cnt[u]);
    check("position", 32'(ps(u)), 32'(pe));
    check("signal_count", 32'(sc(u)), 32'(ce));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    reset_n = 1'b1; bv = 1'b0; bid = '0; ask = '0; thresh = 32'd4;
    a_en = 1'b1; b_en = 1'b0;
    a_if.order_ready = 1'b1;
    b_if.order_ready = 1'b1;
    exp_pos[0] = 0; exp_pos[1] = 0; exp_cnt[0] = 0; exp_cnt[1] = 0;
    #1 reset_n = 1'b0;
    #3;
    check("rst_valid", 32'(a_if.order_valid), 32'd0);
    check("rst_side", 32'(a_if.order_side), 32'd0);
    check("rst_price", a_if.order_price, 32'd0);
    check("rst_position", 32'(a_pos), 32'd0);
    check("rst_count", 32'(a_cnt), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_state", 32'(a_dbg), 32'd0);
`ifdef SIG_DROP_CNT_EN
    check("rst_drop", 32'(a_drop), 32'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;

    // First valid book only seeds the mid.
    run_book(0, 32'd100, 32'd102, 1'b0, 1'b0, 32'd0);

    // Seed then buy at ask; handshake at cycle H, then cooldown window.
    exp_q.push_back({1'b0, 32'd103});
    pulse(32'd101, 32'd103);
    @(posedge clk);
    @(negedge clk);
    check("latency_valid", 32'(a_if.order_valid), 32'd1);
    e = exp_q.pop_front();
    check("buy_side", 32'(a_if.order_side), 32'(e[W]));
    check("buy_price", a_if.order_price, e[W-1:0]);
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      check("cooldown_busy", 32'(a_busy), (i <= 16) ? 32'd1 : 32'd0);
      bid = 32'd102;
      ask = 32'd104;
      bv  = (i == 10 || i == 17);
      if (i == 17) begin
        a_if.order_ready = 1'b0;
        exp_q.push_back({1'b0, 32'd104});
      end
    end
    @(negedge clk);
    bv = 1'b0;
    check("buy_position", 32'(a_pos), 32'd1);
    check("buy_count", 32'(a_cnt), 32'd1);
`ifdef SIG_DROP_CNT_EN
    check("cooldown_drop", 32'(a_drop), 32'd1);
`endif
    @(negedge clk);
    check("post_cool_valid", 32'(a_if.order_valid), 32'd1);
    e = exp_q.pop_front();

    // Backpressure: held for 5 cycles, books dropped meanwhile.
    for (int j = 0; j < 5; j++) begin
      check("bp_valid", 32'(a_if.order_valid), 32'd1);
      check("bp_side", 32'(a_if.order_side), 32'(e[W]));
      check("bp_price", a_if.order_price, e[W-1:0]);
      check("bp_position", 32'(a_pos), 32'd1);
      bv = (j == 1 || j == 3);
      @(negedge clk);
    end
    a_if.order_ready = 1'b1;
    @(negedge clk);
    check("hs_valid_low", 32'(a_if.order_valid), 32'd0);
    check("hs_position", 32'(a_pos), 32'd2);
    check("hs_count", 32'(a_cnt), 32'd2);
`ifdef SIG_DROP_CNT_EN
    check("bp_drop", 32'(a_drop), 32'd3);
`endif
    exp_pos[0] = 2;
    exp_cnt[0] = 2;
    k = 0;
    while (a_busy && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("bp_idle", 32'(a_busy), 32'd0);

    // Filtering (prev_mid = 103).
    run_book(0, 32'd100, 32'd110, 1'b0, 1'b0, 32'd0);     // wide, mid 105
    run_book(0, 32'd103, 32'd105, 1'b1, 1'b1, 32'd103);   // 104 < 105: sell
    run_book(0, 32'd105, 32'd105, 1'b0, 1'b0, 32'd0);     // crossed: ignored
    run_book(0, 32'd103, 32'd105, 1'b0, 1'b0, 32'd0);     // mid equal 104
    run_book(0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0); // ask all-ones
    run_book(0, 32'd103, 32'd105, 1'b0, 1'b0, 32'd0);
    run_book(0, 32'd0, 32'd10, 1'b0, 1'b0, 32'd0);        // zero bid
    run_book(0, 32'd103, 32'd105, 1'b0, 1'b0, 32'd0);
    run_book(0, 32'd103, 32'd107, 1'b1, 1'b0, 32'd107);   // spread == thresh
    run_book(0, 32'd104, 32'd109, 1'b0, 1'b0, 32'd0);     // spread 5, mid 106
`ifdef SIG_DROP_CNT_EN
    check("filter_drop", 32'(a_drop), 32'd3);
`endif

    // Position limit on instance B (limit 2, no cooldown).
    a_en = 1'b0;
    b_en = 1'b1;
    run_book(1, 32'd100, 32'd102, 1'b0, 1'b0, 32'd0);
    run_book(1, 32'd101, 32'd103, 1'b1, 1'b0, 32'd103);
    run_book(1, 32'd102, 32'd104, 1'b1, 1'b0, 32'd104);
    run_book(1, 32'd103, 32'd105, 1'b0, 1'b0, 32'd0);     // at +2: blocked
    run_book(1, 32'd102, 32'd104, 1'b1, 1'b1, 32'd102);

    // Reset while an order is pending on A.
    a_en = 1'b1;
    b_en = 1'b0;
    a_if.order_ready = 1'b0;
    exp_q.push_back({1'b0, 32'd108});
    pulse(32'd106, 32'd108);
    @(posedge clk);
    @(negedge clk);
    check("pend_valid", 32'(a_if.order_valid), 32'd1);
    e = exp_q.pop_front();
    check("pend_price", a_if.order_price, e[W-1:0]);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(a_if.order_valid), 32'd0);
    check("mid_rst_position", 32'(a_pos), 32'd0);
    check("mid_rst_count", 32'(a_cnt), 32'd0);
    check("mid_rst_busy", 32'(a_busy), 32'd0);
    check("mid_rst_price", a_if.order_price, 32'd0);
    check("mid_rst_b_position", 32'(b_pos), 32'd0);
`ifdef SIG_DROP_CNT_EN
    check("mid_rst_drop", 32'(a_drop), 32'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    a_if.order_ready = 1'b1;
    exp_pos[0] = 0; exp_pos[1] = 0; exp_cnt[0] = 0; exp_cnt[1] = 0;
    run_book(0, 32'd106, 32'd108, 1'b0, 1'b0, 32'd0);     // seeds only
    run_book(0, 32'd107, 32'd109, 1'b1, 1'b0, 32'd109);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
